// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC capture path.
// State encodings and the framer sample-count width.
package xadc_pkg;

  localparam int CNT_W_DEF = 25;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with zero flag.
// Holds at zero; load has priority over enable.
module seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/xadc_capture_sequencer.sv
// Burst sequencer for the XADC TLAST framer.
// Issues framer starts and watches the framed stream for loss/timeouts.
module xadc_capture_sequencer
  import xadc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = 16,
  parameter int GAP_W = 16,
  parameter int TMO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [FRM_W-1:0] cfg_frames,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [TMO_W-1:0] cfg_timeout,
  output logic             tl_start,
  output logic [CNT_W-1:0] tl_count,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             busy,
  output logic             done,
  output logic [FRM_W-1:0] frames_done,
  output logic             err_cfg,
  output logic             err_overflow,
  output logic             err_timeout
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [FRM_W-1:0] fdone_q, fdone_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic             ecfg_q, ecfg_d;
  logic             eovf_q, eovf_d;
  logic             etmo_q, etmo_d;

  logic             gap_load, gap_en, gap_zero;
  logic             tmo_load, tmo_en, tmo_zero;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             frame_end;
  logic             last_frame;
  logic [FRM_W:0]   fdone_inc;

  assign frame_end = mon_tvalid & mon_tlast;
  assign fdone_inc = {1'b0, fdone_q} + 1'b1;
  assign last_frame = (frames_q != '0) &&
                      (fdone_inc == {1'b0, frames_q});

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    fdone_d  = fdone_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    ecfg_d   = ecfg_q;
    eovf_d   = eovf_q;
    etmo_d   = etmo_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start && cfg_count != '0) begin
          count_d  = cfg_count;
          frames_d = cfg_frames;
          gap_d    = cfg_gap;
          tmo_d    = cfg_timeout;
          fdone_d  = '0;
          abort_d  = 1'b0;
          ecfg_d   = 1'b0;
          eovf_d   = 1'b0;
          etmo_d   = 1'b0;
          state_d  = ST_ARM;
        end else if (cmd_start) begin
          ecfg_d = 1'b1;
        end
      end
      ST_ARM: begin
        abort_d  = abort_q | cmd_abort;
        tmo_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        abort_d = abort_q | cmd_abort;
        tmo_en  = 1'b1;
        // frame end takes priority over a coincident timeout
        if (frame_end) begin
          if (fdone_q != '1)
            fdone_d = fdone_q + 1'b1;
          if (last_frame || abort_d) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else if (gap_q != '0) begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end else begin
            state_d = ST_ARM;
          end
        end else if (tmo_q != '0 && tmo_zero) begin
          etmo_d  = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_GAP: begin
        abort_d = abort_q | cmd_abort;
        if (abort_d) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          abort_d = 1'b0;
        end else if (gap_zero) begin
          state_d = ST_ARM;
        end else begin
          gap_en = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (mon_tvalid && !mon_tready)
      eovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      fdone_q  <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      ecfg_q   <= 1'b0;
      eovf_q   <= 1'b0;
      etmo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      fdone_q  <= fdone_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      ecfg_q   <= ecfg_d;
      eovf_q   <= eovf_d;
      etmo_q   <= etmo_d;
    end
  end

  // loaded with N-1 so zero marks the Nth cycle
  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - 1'b1),
    .en       (gap_en),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  seq_down_counter #(.W(TMO_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (tmo_q - 1'b1),
    .en       (tmo_en),
    .cnt      (tmo_cnt),
    .zero     (tmo_zero)
  );

  assign tl_start     = (state_q == ST_ARM);
  assign tl_count     = count_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign frames_done  = fdone_q;
  assign err_cfg      = ecfg_q;
  assign err_overflow = eovf_q;
  assign err_timeout  = etmo_q;

endmodule
